// File: rtl/posit_mult_issue.sv
// posit_mult_issue: credit-based issue/collect wrapper around a fixed-latency
// posit multiplier. Operands are issued only when a result FIFO slot is
// reserved, so the multiplier output never needs backpressure.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_FLUSH | after reset; multiplier pipe may hold stale products, ignore done
// ST_RUN   | normal issue/collect until the next reset
module posit_mult_issue #(
    parameter int N       = 16,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [N-1:0]             s_in1,
    input  logic [N-1:0]             s_in2,
    output logic [N-1:0]             mul_in1,
    output logic [N-1:0]             mul_in2,
    output logic                     mul_start,
    input  logic [N-1:0]             mul_result,
    input  logic                     mul_inf,
    input  logic                     mul_zero,
    input  logic                     mul_done,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [N-1:0]             m_result,
    output logic                     m_inf,
    output logic                     m_zero,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err_stray
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(LATENCY + 1);
    localparam int EW = N + 2;
    localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [FW-1:0]              flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]              inflight_q, inflight_d;
    logic [CW-1:0]              count_q, count_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic                       err_stray_q, err_stray_d;
    logic [DEPTH-1:0][EW-1:0]   mem_q, mem_d;

    logic        run;
    logic [CW:0] occupancy;
    logic        issue;
    logic        push;
    logic        stray;
    logic        pop;
    logic [EW-1:0] head;

    // Next-state logic: hold FLUSH for LATENCY cycles so stale products drain.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_FLUSH) begin
            if (flush_cnt_q != '0) begin
                flush_cnt_d = flush_cnt_q - FW'(1);
            end
            if (flush_cnt_q <= FW'(1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Issue/collect handshakes; credit uses registered counts only.
    always_comb begin
        run       = (state_q == ST_RUN);
        occupancy = {1'b0, inflight_q} + {1'b0, count_q};
        s_ready   = run && (occupancy < DEPTH_OCC);
        issue     = s_valid && s_ready;
        mul_start = issue;
        mul_in1   = issue ? s_in1 : '0;
        mul_in2   = issue ? s_in2 : '0;
        push      = run && mul_done && (inflight_q != '0);
        stray     = run && mul_done && (inflight_q == '0);
        m_valid   = (count_q != '0);
        pop       = m_valid && m_ready;
        head      = mem_q[rd_ptr_q];
        m_result  = head[EW-1:2];
        m_inf     = head[1];
        m_zero    = head[0];
        inflight  = inflight_q;
        err_stray = err_stray_q;
    end

    // Counter and FIFO next values; simultaneous issue/done/pop all combine.
    always_comb begin
        inflight_d  = inflight_q + CW'(issue) - CW'(push);
        count_d     = count_q + CW'(push) - CW'(pop);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        err_stray_d = err_stray_q | stray;
        if (push) begin
            mem_d[wr_ptr_q] = {mul_result, mul_inf, mul_zero};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // State registers; reset discards all in-flight and buffered results.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= FW'(LATENCY);
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_stray_q <= 1'b0;
            mem_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_stray_q <= err_stray_d;
            mem_q       <= mem_d;
        end
    end

endmodule

// File: tb/tb_posit_mult_issue.sv
// Bench for posit_mult_issue: a stand-in fixed-latency multiplier, a
// queue-based reference of issued products, and a per-cycle compare.
module tb_posit_mult_issue;

    localparam int N     = 16;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          s_valid;
    logic          s_ready;
    logic [N-1:0]  s_in1, s_in2;
    logic [N-1:0]  mul_in1, mul_in2;
    logic          mul_start;
    logic [N-1:0]  mul_result;
    logic          mul_inf, mul_zero, mul_done;
    logic          m_valid, m_ready;
    logic [N-1:0]  m_result;
    logic          m_inf, m_zero;
    logic [3:0]    inflight;
    logic          err_stray;
    logic          stray_pulse;

    int n_chk  = 0;
    int n_pass = 0;

    posit_mult_issue #(.N(N), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_in1(s_in1), .s_in2(s_in2),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
        .mul_result(mul_result), .mul_inf(mul_inf), .mul_zero(mul_zero),
        .mul_done(mul_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result),
        .m_inf(m_inf), .m_zero(m_zero),
        .inflight(inflight), .err_stray(err_stray)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Stand-in posit multiplier, packed as {result, inf, zero}.
    function automatic logic [17:0] fmul(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h8000 || b == 16'h8000) return {16'h8000, 1'b1, 1'b0};
        if (a == 16'h0000 || b == 16'h0000) return {16'h0000, 1'b0, 1'b1};
        if (a == 16'h4000) return {b, 2'b00};
        if (b == 16'h4000) return {a, 2'b00};
        if (a == 16'h4400 && b == 16'h4400) return {16'h4800, 2'b00};
        return {((a * 16'd3) ^ (b * 16'd5) ^ 16'h1234) | 16'h0001, 2'b00};
    endfunction

    // Multiplier pipe: no reset, start at cycle t -> done at cycle t+LAT.
    logic [3:0]        pv = '0;
    logic [3:0][17:0]  pd = '0;
    always @(posedge aclk) begin
        pv <= {pv[2:0], mul_start};
        pd <= {pd[2:0], fmul(mul_in1, mul_in2)};
    end
    assign mul_done   = pv[3] | stray_pulse;
    assign mul_result = pd[3][17:2];
    assign mul_inf    = pd[3][1];
    assign mul_zero   = pd[3][0];

    // Reference: queue of issued products with the cycle each becomes visible.
    typedef struct {
        logic [17:0] d;
        int          avail;
    } item_t;
    item_t q[$];
    int    cyc       = 0;
    int    since_rel = 0;
    logic  err_e     = 1'b0;

    function automatic logic run_e();
        return aresetn === 1'b1 && since_rel >= LAT;
    endfunction
    function automatic logic s_ready_e();
        return run_e() && q.size() < DEPTH;
    endfunction
    function automatic int inflight_e();
        int n = 0;
        foreach (q[i]) if (q[i].avail > cyc) n++;
        return n;
    endfunction
    function automatic logic m_valid_e();
        return q.size() > 0 && q[0].avail <= cyc;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        logic  iss, pp;
        item_t it;
        if (!aresetn) begin
            q.delete();
            since_rel = 0;
            err_e     = 1'b0;
        end else begin
            iss = s_valid && s_ready_e();
            pp  = m_valid_e() && m_ready;
            if (run_e() && stray_pulse && inflight_e() == 0) err_e = 1'b1;
            if (pp) q.delete(0);
            if (iss) begin
                it.d     = fmul(s_in1, s_in2);
                it.avail = cyc + LAT + 1;
                q.push_back(it);
            end
            if (since_rel < LAT) since_rel++;
            cyc++;
        end
    end

    // Compare every output against the reference, mid-cycle.
    always @(negedge aclk) begin
        logic iss;
        iss = s_valid && s_ready_e();
        chk("s_ready",   32'(s_ready),   32'(s_ready_e()));
        chk("mul_start", 32'(mul_start), 32'(iss));
        chk("mul_in1",   32'(mul_in1),   32'(iss ? s_in1 : 16'h0));
        chk("mul_in2",   32'(mul_in2),   32'(iss ? s_in2 : 16'h0));
        chk("m_valid",   32'(m_valid),   32'(m_valid_e()));
        chk("inflight",  32'(inflight),  32'(inflight_e()));
        chk("err_stray", 32'(err_stray), 32'(err_e));
        if (m_valid_e()) begin
            chk("m_result", 32'(m_result), 32'(q[0].d[17:2]));
            chk("m_inf",    32'(m_inf),    32'(q[0].d[1]));
            chk("m_zero",   32'(m_zero),   32'(q[0].d[0]));
        end
        if (!aresetn) begin
            chk("rst_m_result", 32'({m_result, m_inf, m_zero}), 32'h0);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while ((m_valid || inflight != 0) && k < 50) begin
            step();
            k++;
        end
        chk("drain_timeout", 32'(k >= 50), 32'h0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h4000;
            3: return 16'h4400;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int k, lat, issued, got, bad, first_c, last_c, peak, pops, seen;
        aresetn     = 1'b0;
        s_valid     = 1'b1;
        s_in1       = 16'h4000;
        s_in2       = 16'h4000;
        m_ready     = 1'b1;
        stray_pulse = 1'b0;
        repeat (3) step();
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);

        // Flush window after reset release, then a single 1.0*1.0 issue.
        aresetn = 1'b1;
        k = 0;
        while (!s_ready && k < 20) begin
            step();
            k++;
        end
        chk("flush_cycles", 32'(k), 32'(LAT));
        step();
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("first_latency", 32'(lat), 32'd5);
        chk("one_result", 32'(m_result), 32'h4000);
        chk("one_inf",    32'(m_inf),    32'h0);
        chk("one_zero",   32'(m_zero),   32'h0);

        // Sustained stream of 2.0*2.0.
        drain();
        s_in1 = 16'h4400;
        s_in2 = 16'h4400;
        s_valid = 1'b1;
        issued = 0; got = 0; bad = 0; first_c = -1; last_c = -1; peak = 0; k = 0;
        while (got < 20 && k < 200) begin
            if (s_valid && s_ready) issued++;
            if (m_valid && m_ready) begin
                if (first_c < 0) first_c = k;
                last_c = k;
                got++;
                if (m_result != 16'h4800) bad++;
            end
            if (int'(inflight) > peak) peak = int'(inflight);
            step();
            k++;
            if (issued == 20) s_valid = 1'b0;
        end
        chk("stream_count", 32'(got), 32'd20);
        chk("stream_bad", 32'(bad), 32'h0);
        chk("stream_span", 32'(last_c - first_c), 32'd19);
        chk("stream_peak", 32'(peak), 32'(LAT));

        // Backpressure: credit limits outstanding products to DEPTH.
        drain();
        m_ready = 1'b0;
        s_valid = 1'b1;
        issued = 0;
        for (int i = 0; i < 30; i++) begin
            if (s_valid && s_ready) issued++;
            step();
        end
        chk("bp_issues", 32'(issued), 32'(DEPTH));
        chk("bp_s_ready", 32'(s_ready), 32'h0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 15; i++) begin
            if (m_valid && m_ready) pops++;
            step();
        end
        chk("bp_pops", 32'(pops), 32'(DEPTH));
        s_valid = 1'b1;
        chk("bp_resume", 32'(s_ready), 32'h1);
        step();
        s_valid = 1'b0;

        // Zero and NaR products back to back.
        drain();
        s_valid = 1'b1;
        s_in1 = 16'h0000; s_in2 = 16'h0000;
        step();
        s_in1 = 16'h8000; s_in2 = 16'h4000;
        step();
        s_valid = 1'b0;
        k = 0;
        while (!m_valid && k < 20) begin
            step();
            k++;
        end
        chk("zero_result", 32'(m_result), 32'h0000);
        chk("zero_flag", 32'(m_zero), 32'h1);
        step();
        chk("nar_result", 32'(m_result), 32'h8000);
        chk("nar_flag", 32'(m_inf), 32'h1);

        // Randomized traffic.
        drain();
        for (int i = 0; i < 500; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_in1   = pick();
            s_in2   = pick();
            m_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        // Stray done with nothing in flight.
        drain();
        stray_pulse = 1'b1;
        step();
        stray_pulse = 1'b0;
        chk("stray_set", 32'(err_stray), 32'h1);
        chk("stray_no_valid", 32'(m_valid), 32'h0);
        repeat (3) step();
        chk("stray_sticky", 32'(err_stray), 32'h1);

        // Reset with three products in flight.
        s_in1 = 16'h4000; s_in2 = 16'h4400;
        s_valid = 1'b1;
        issued = 0; k = 0;
        while (issued < 3 && k < 20) begin
            if (s_ready) issued++;
            step();
            k++;
        end
        s_valid = 1'b0;
        chk("pre_rst_inflight", 32'(inflight), 32'd3);
        aresetn = 1'b0;
        #1;
        chk("rst_err_clear", 32'(err_stray), 32'h0);
        step();
        step();
        aresetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_valid) seen++;
            step();
        end
        chk("post_rst_no_results", 32'(seen), 32'h0);
        chk("post_rst_inflight", 32'(inflight), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
